// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM 8-lane receive demultiplexer.
// TDM_PARITY_EN adds a trailing even-parity slot to every frame.
package tdm_pkg;

  localparam int LANES = 8;

`ifdef TDM_PARITY_EN
  localparam int SEL_W     = $clog2(LANES + 1);
  localparam int LAST_SLOT = LANES;
`else
  localparam int SEL_W     = $clog2(LANES);
  localparam int LAST_SLOT = LANES - 1;
`endif

  typedef logic [SEL_W-1:0] slot_t;

  localparam slot_t LAST_SEL = slot_t'(LAST_SLOT);

endpackage

// File: rtl/tdm_demux8_if.sv
// Link-side and parallel-side signals of tdm_demux8, grouped with master/slave views.
// Handshake: din is sampled on a rising edge only when en=1; sync=1 restarts the frame at slot 0.
interface tdm_demux8_if;
  import tdm_pkg::*;

  logic             din;
  logic             en;
  logic             sync;
  slot_t            sel;
  logic [LANES-1:0] q;
  logic             q_valid;
  logic             sync_err;
  logic             par_err;

  modport slave (
    input  din, en, sync,
    output sel, q, q_valid, sync_err, par_err
  );

  modport master (
    output din, en, sync,
    input  sel, q, q_valid, sync_err, par_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index register for the TDM frame: advances on en, clears on sync, wraps at LAST_SEL.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  logic  sync_i,
  output slot_t sel_o,
  output logic  wrap_o,
  output logic  at_zero_o
);

  slot_t sel_q, sel_d;

  always_comb begin
    sel_d  = sel_q;
    wrap_o = 1'b0;
    if (sync_i) begin
      // A sync with valid data consumes slot 0, so the next slot is 1.
      sel_d = en_i ? slot_t'(1) : '0;
    end else if (en_i) begin
      if (sel_q == LAST_SEL) begin
        sel_d  = '0;
        wrap_o = 1'b1;
      end else begin
        sel_d = sel_q + slot_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= '0;
    else        sel_q <= sel_d;
  end

  assign sel_o     = sel_q;
  assign at_zero_o = (sel_q == '0);

endmodule

// File: rtl/tdm_demux8.sv
// Rebuilds an 8-bit parallel word from a one-bit-per-slot TDM stream and drives the remote mux select.
// Optional macro TDM_PARITY_EN: extra parity slot per frame, checked into par_err.
module tdm_demux8
  import tdm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux8_if.slave  bus
);

  slot_t sel;
  logic  wrap;
  logic  at_zero;

  tdm_slot_counter u_slot_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (bus.en),
    .sync_i    (bus.sync),
    .sel_o     (sel),
    .wrap_o    (wrap),
    .at_zero_o (at_zero)
  );

  logic [LANES-1:0] staging_q, staging_d;
  logic [LANES-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             sync_err_q, sync_err_d;
`ifdef TDM_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  always_comb begin
    staging_d  = staging_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    sync_err_d = bus.sync & ~at_zero;
`ifdef TDM_PARITY_EN
    par_err_d  = 1'b0;
`endif
    if (bus.sync) begin
      // Sync always wins, even on the last slot: the partial frame is dropped.
      staging_d = bus.en ? {{(LANES-1){1'b0}}, bus.din} : '0;
    end else if (bus.en) begin
      if (wrap) begin
`ifdef TDM_PARITY_EN
        q_d       = staging_q;
        par_err_d = (^staging_q) ^ bus.din;
`else
        q_d            = staging_q;
        q_d[LANES-1]   = bus.din;
`endif
        q_valid_d = 1'b1;
        staging_d = '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (sel == slot_t'(i)) staging_d[i] = bus.din;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q  <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      staging_q  <= staging_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      sync_err_q <= sync_err_d;
    end
  end

`ifdef TDM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.sel      = sel;
  assign bus.q        = q_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: frame vector table, scoreboard of completed words, and hand-written sync/reset sequences.
module tb_tdm_demux8;
  import tdm_pkg::*;

`ifdef TDM_PARITY_EN
  localparam int FRAME = LANES + 1;
`else
  localparam int FRAME = LANES;
`endif

  logic clk;
  logic rst_n;

  tdm_demux8_if dut_if ();

  tdm_demux8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard: {par_err, q}
  logic [8:0] exp_q[$];
  int         valid_cyc[$];
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (dut_if.q_valid) begin
        valid_cyc.push_back(cyc);
        if (prev_valid) check("q_valid_back_to_back", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_q_valid", {31'd0, dut_if.q_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("q", {24'd0, dut_if.q}, {24'd0, e[7:0]});
          check("par_err", {31'd0, dut_if.par_err}, {31'd0, e[8]});
        end
      end else if (dut_if.par_err) begin
        check("par_err_without_q_valid", {31'd0, dut_if.par_err}, 32'd0);
      end
      prev_valid = dut_if.q_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // driver tasks
  task automatic drive_bit(input logic d, input logic e, input logic s);
    dut_if.din  = d;
    dut_if.en   = e;
    dut_if.sync = s;
    @(posedge clk);
    #1;
  endtask

  // Sends data LSB first from slot 'start'; gaps[i] inserts an en=0 cycle before bit i.
  task automatic drive_frame(input logic [7:0] data, input logic [7:0] gaps,
                             input logic flip, input int start);
    slot_t s;
    for (int i = start; i < LANES; i++) begin
      if (gaps[i]) begin
        s = dut_if.sel;
        drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("sel_hold_en0", {{(32-SEL_W){1'b0}}, dut_if.sel}, {{(32-SEL_W){1'b0}}, s});
      end
`ifndef TDM_PARITY_EN
      if (i == LANES - 1) exp_q.push_back({1'b0, data});
`endif
      drive_bit(data[i], 1'b1, 1'b0);
    end
`ifdef TDM_PARITY_EN
    exp_q.push_back({flip, data});
    drive_bit((^data) ^ flip, 1'b1, 1'b0);
`else
    if (flip) s = '0;
`endif
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] gaps;
    logic       flip;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{data: 8'hA5, gaps: 8'h00, flip: 1'b0};
    tbl[1] = '{data: 8'h3C, gaps: 8'h00, flip: 1'b0};
    tbl[2] = '{data: 8'hFF, gaps: 8'hAA, flip: 1'b0};
    tbl[3] = '{data: 8'h0F, gaps: 8'h00, flip: 1'b0};
    tbl[4] = '{data: 8'h0F, gaps: 8'h00, flip: 1'b1};
    for (int i = 5; i < 8; i++) begin
      tbl[i].data = 8'($urandom_range(0, 255));
      tbl[i].gaps = 8'($urandom_range(0, 255));
      tbl[i].flip = 1'($urandom_range(0, 1));
    end

    rst_n = 1'b0;
    dut_if.din  = 1'b0;
    dut_if.en   = 1'b0;
    dut_if.sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd0);
    check("rst_q", {24'd0, dut_if.q}, 32'd0);
    check("rst_q_valid", {31'd0, dut_if.q_valid}, 32'd0);
    check("rst_sync_err", {31'd0, dut_if.sync_err}, 32'd0);
    check("rst_par_err", {31'd0, dut_if.par_err}, 32'd0);
    rst_n = 1'b1;
    drive_bit(1'b0, 1'b0, 1'b0);

    // single frame 0x4D
    drive_frame(8'h4D, 8'h00, 1'b0, 0);
    check("t1_q_valid_now", {31'd0, dut_if.q_valid}, 32'd1);
    drive_bit(1'b0, 1'b0, 1'b0);
    check("t1_sel_wrapped", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd0);
    check("t1_q_held", {24'd0, dut_if.q}, 32'h4D);
    check("t1_q_valid_pulse", {31'd0, dut_if.q_valid}, 32'd0);

    // vector table, frames sent back to back
    valid_cyc.delete();
    for (int i = 0; i < 8; i++) drive_frame(tbl[i].data, tbl[i].gaps, tbl[i].flip, 0);
    drive_bit(1'b0, 1'b0, 1'b0);
    if (valid_cyc.size() >= 2) check("frame_spacing", valid_cyc[1] - valid_cyc[0], FRAME);
    else check("frame_spacing_count", valid_cyc.size(), 8);

    // sync at slot 0 is silent
    drive_bit(1'b0, 1'b0, 1'b1);
    check("sync_at_zero_err", {31'd0, dut_if.sync_err}, 32'd0);
    check("sync_at_zero_sel", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd0);

    // sync with data at slot 5
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1, 1'b0);
    check("pre_sync_sel", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd5);
    drive_bit(1'b1, 1'b1, 1'b1);
    check("sync5_err", {31'd0, dut_if.sync_err}, 32'd1);
    check("sync5_sel", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd1);
    check("sync5_no_valid", {31'd0, dut_if.q_valid}, 32'd0);
    drive_bit(1'b0, 1'b0, 1'b0);
    check("sync5_err_pulse", {31'd0, dut_if.sync_err}, 32'd0);
    drive_frame(8'h61, 8'h00, 1'b0, 1);

    // sync without data mid-frame
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b1);
    check("sync_noen_err", {31'd0, dut_if.sync_err}, 32'd1);
    check("sync_noen_sel", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd0);
    drive_frame(8'hC3, 8'h00, 1'b0, 0);

    // sync on the last slot wins over frame completion
    for (int i = 0; i < FRAME - 1; i++) drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b1);
    check("sync_last_err", {31'd0, dut_if.sync_err}, 32'd1);
    check("sync_last_no_valid", {31'd0, dut_if.q_valid}, 32'd0);
    check("sync_last_sel", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd1);
    drive_frame(8'h5B, 8'h00, 1'b0, 1);

    // asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_sel", {{(32-SEL_W){1'b0}}, dut_if.sel}, 32'd0);
    check("arst_q", {24'd0, dut_if.q}, 32'd0);
    check("arst_q_valid", {31'd0, dut_if.q_valid}, 32'd0);
    dut_if.en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_frame(8'h96, 8'h00, 1'b0, 0);

    repeat (3) drive_bit(1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
